// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants for the instruction-fetch front end.
//   PS_*  : PC-select encodings presented by decode on the consume cycle.
//   ST_*  : fetch FSM state encodings.
// -----------------------------------------------------------------------------
package fetch_pkg;

    // PC-select codes
    localparam logic [1:0] PS_HOLD = 2'b00;  // keep ir_pc and halt
    localparam logic [1:0] PS_INC  = 2'b01;  // ir_pc + INC
    localparam logic [1:0] PS_REG  = 2'b10;  // absolute register target
    localparam logic [1:0] PS_REL  = 2'b11;  // ir_pc + (sext(imm) << SHIFT)

    // FSM states
    localparam logic [1:0] ST_FETCH      = 2'b00;  // request outstanding at pc
    localparam logic [1:0] ST_FULL       = 2'b01;  // instruction buffered for decode
    localparam logic [1:0] ST_HALT       = 2'b10;  // stopped until resume or flush
    localparam logic [1:0] ST_FLUSH_WAIT = 2'b11;  // draining a request made before a flush

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the two handshakes of the fetch stage:
//   imem_*  : request to instruction memory (req/addr out, data/valid back)
//   ir_*    : buffered instruction offered to decode (valid/data/pc out, ready back)
// Modports:
//   master : the fetch unit
//   slave  : the memory + decode side
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               imem_valid;

    logic               ir_valid;
    logic               ir_ready;
    logic [INSTR_W-1:0] ir_data;
    logic [ADDR_W-1:0]  ir_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_data, imem_valid,
        output ir_valid, ir_data, ir_pc,
        input  ir_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_data, imem_valid,
        input  ir_valid, ir_data, ir_pc,
        output ir_ready
    );
endinterface

// File: rtl/fetch_unit_next_pc.sv
// -----------------------------------------------------------------------------
// fetch_next_pc
// Combinational next-PC selection.
//   ps         in  2-bit PC select (fetch_pkg::PS_*)
//   ir_pc      in  address of the instruction being consumed
//   reg_target in  absolute jump target
//   branch_imm in  signed relative offset, scaled by << SHIFT
//   next_pc    out selected next PC (modulo 2^ADDR_W)
// -----------------------------------------------------------------------------
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int IMM_W  = 26,
    parameter int SHIFT  = 2,
    parameter int INC    = 4
) (
    input  logic [1:0]        ps,
    input  logic [ADDR_W-1:0] ir_pc,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic [IMM_W-1:0]  branch_imm,
    output logic [ADDR_W-1:0] next_pc
);
    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] rel_pc;

    // Size-casting a signed operand replicates bit IMM_W-1 into the upper bits.
    assign imm_ext = ADDR_W'($signed(branch_imm));
    assign seq_pc  = ir_pc + ADDR_W'(INC);
    assign rel_pc  = ir_pc + (imm_ext << SHIFT);

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        next_pc = ir_pc;
        case (ps)
            PS_INC:  next_pc = seq_pc;
            PS_REG:  next_pc = reg_target;
            PS_REL:  next_pc = rel_pc;
            default: next_pc = ir_pc;
        endcase
    end
endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Clocked instruction-fetch stage: holds the PC, issues requests to a
// variable-latency instruction memory, buffers one instruction for decode and
// selects the next PC when decode consumes it. Supports halt/resume, an
// external flush/redirect and a retired-instruction counter.
//   clock, reset  single rising-edge clock, asynchronous active-high reset
//   bus           fetch_unit_if.master: imem request/response + ir handshake
//   ps            PC select, sampled on consume
//   reg_target    absolute target for PS_REG
//   branch_imm    relative offset for PS_REL
//   flush         redirect pulse to flush_pc (beats everything but reset)
//   resume        leave HALT
//   halted        high while in HALT
//   retire_count  number of consumed instructions (wraps)
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter int                IMM_W    = 26,
    parameter int                SHIFT    = 2,
    parameter int                INC      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    fetch_unit_if.master      bus,
    input  logic [1:0]        ps,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic [IMM_W-1:0]  branch_imm,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              resume,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_count
);
    if (IMM_W + SHIFT > ADDR_W) begin : g_param_check
        $error("fetch_unit: IMM_W + SHIFT must not exceed ADDR_W");
    end

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  stale_q, stale_d;   // address still owed a response after a flush
    logic               ir_valid_q, ir_valid_d;
    logic [INSTR_W-1:0] ir_data_q, ir_data_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  next_pc;
    logic               consume;

    fetch_next_pc #(
        .ADDR_W (ADDR_W),
        .IMM_W  (IMM_W),
        .SHIFT  (SHIFT),
        .INC    (INC)
    ) u_next_pc (
        .ps         (ps),
        .ir_pc      (ir_pc_q),
        .reg_target (reg_target),
        .branch_imm (branch_imm),
        .next_pc    (next_pc)
    );

    assign consume = ir_valid_q & bus.ir_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        stale_d    = stale_q;
        ir_valid_d = ir_valid_q;
        ir_data_d  = ir_data_q;
        ir_pc_d    = ir_pc_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_FETCH: begin
                if (flush) begin
                    // A response arriving with the flush is simply dropped; otherwise
                    // the memory still owes one for the old address, so wait it out.
                    pc_d = flush_pc;
                    if (!bus.imem_valid) begin
                        stale_d = pc_q;
                        state_d = ST_FLUSH_WAIT;
                    end
                end else if (bus.imem_valid) begin
                    ir_data_d  = bus.imem_data;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    state_d    = ST_FULL;
                end
            end
            ST_FULL: begin
                if (flush) begin
                    ir_valid_d = 1'b0;
                    pc_d       = flush_pc;
                    state_d    = ST_FETCH;
                end else if (consume) begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    ir_valid_d = 1'b0;
                    pc_d       = next_pc;
                    state_d    = (ps == PS_HOLD) ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                if (flush) begin
                    ir_valid_d = 1'b0;
                    pc_d       = flush_pc;
                    state_d    = ST_FETCH;
                end else if (resume) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FLUSH_WAIT: begin
                if (flush) begin
                    pc_d = flush_pc;
                end
                if (bus.imem_valid) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            stale_q    <= '0;
            ir_valid_q <= 1'b0;
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register see pre-edge values, independent of statement order.
            state_q    <= state_d;
            pc_q       <= pc_d;
            stale_q    <= stale_d;
            ir_valid_q <= ir_valid_d;
            ir_data_q  <= ir_data_d;
            ir_pc_q    <= ir_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.imem_req  = (state_q == ST_FETCH) || (state_q == ST_FLUSH_WAIT);
    assign bus.imem_addr = (state_q == ST_FLUSH_WAIT) ? stale_q : pc_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.ir_data   = ir_data_q;
    assign bus.ir_pc     = ir_pc_q;
    assign halted        = (state_q == ST_HALT);
    assign retire_count  = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A behavioural memory answers each request
// after a programmable number of wait cycles with a word derived from its
// address. Expected fetch addresses and expected consumed instructions are
// queued as stimulus is driven and compared by a monitor as the DUT produces
// them.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  ps;
    logic [63:0] reg_target;
    logic [25:0] branch_imm;
    logic        flush;
    logic [63:0] flush_pc;
    logic        resume;
    logic        halted;
    logic [31:0] retire_count;

    int n_checks = 0;
    int n_fail   = 0;
    int latency  = 0;
    int lat_cnt;
    int cyc      = 0;
    int exp_retire = 0;

    logic [63:0] exp_fetch_q[$];
    logic [63:0] exp_ir_q[$];
    int          fetch_cyc[$];

    fetch_unit_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

    fetch_unit dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .ps           (ps),
        .reg_target   (reg_target),
        .branch_imm   (branch_imm),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .resume       (resume),
        .halted       (halted),
        .retire_count (retire_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_A5A5;
    endfunction

    // Memory: answers after `latency` wait cycles of a held request.
    always @(posedge clock or posedge reset) begin
        if (reset) lat_cnt <= 0;
        else if (bus.imem_req && !bus.imem_valid) lat_cnt <= lat_cnt + 1;
        else lat_cnt <= 0;
    end
    assign bus.imem_valid = bus.imem_req && (lat_cnt >= latency);
    assign bus.imem_data  = bus.imem_valid ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: sampled just after the falling edge, when inputs for
    // the coming rising edge are settled.
    always @(negedge clock) begin
        logic [63:0] e;
        #1;
        if (!reset) begin
            if (bus.imem_req && bus.imem_valid) begin
                fetch_cyc.push_back(cyc);
                e = (exp_fetch_q.size() > 0) ? exp_fetch_q.pop_front() : '1;
                chk("fetch_addr", bus.imem_addr, e);
            end
            if (bus.ir_valid && bus.ir_ready && !flush) begin
                e = (exp_ir_q.size() > 0) ? exp_ir_q.pop_front() : '1;
                chk("consume_pc", bus.ir_pc, e);
                chk("consume_data", {32'h0, bus.ir_data}, {32'h0, mem_word(e)});
            end
        end
    end

    task automatic wait_ir_valid(input logic [63:0] exp_pc);
        bit got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.ir_valid) begin
                got = 1;
                break;
            end
        end
        chk("ir_valid_timeout", {63'h0, got}, 64'h1);
        chk("ir_pc", bus.ir_pc, exp_pc);
        chk("ir_data", {32'h0, bus.ir_data}, {32'h0, mem_word(exp_pc)});
    endtask

    // Called on a falling edge with an instruction buffered; consumes it.
    task automatic consume(input logic [1:0] sel, input logic [63:0] tgt, input logic [25:0] imm,
                           input logic [63:0] cur_pc, input logic [63:0] nxt, input bit fetches);
        exp_ir_q.push_back(cur_pc);
        if (fetches) exp_fetch_q.push_back(nxt);
        exp_retire++;
        ps         = sel;
        reg_target = tgt;
        branch_imm = imm;
        bus.ir_ready = 1'b1;
        @(negedge clock);
        bus.ir_ready = 1'b0;
        if (fetches) begin
            chk("next_req", {63'h0, bus.imem_req}, 64'h1);
            chk("next_addr", bus.imem_addr, nxt);
        end
    endtask

    initial begin
        bit got;
        reset = 1'b1;
        ps = PS_INC; reg_target = '0; branch_imm = '0;
        flush = 1'b0; flush_pc = '0; resume = 1'b0;
        bus.ir_ready = 1'b0;
        #1;
        chk("rst_ir_valid", {63'h0, bus.ir_valid}, 64'h0);
        chk("rst_retire", {32'h0, retire_count}, 64'h0);
        chk("rst_halted", {63'h0, halted}, 64'h0);
        chk("rst_req", {63'h0, bus.imem_req}, 64'h1);
        chk("rst_addr", bus.imem_addr, 64'h0);
        repeat (2) @(negedge clock);

        // Sequential fetch with a 0-wait memory.
        for (int i = 0; i < 5; i++) exp_fetch_q.push_back(64'(4 * i));
        for (int i = 0; i < 4; i++) exp_ir_q.push_back(64'(4 * i));
        exp_retire = 4;
        bus.ir_ready = 1'b1;
        reset = 1'b0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (retire_count == 32'd4) begin
                got = 1;
                break;
            end
        end
        bus.ir_ready = 1'b0;
        chk("seq_retire", {32'h0, retire_count}, 64'd4);
        for (int i = 0; i < 3; i++)
            chk("seq_cadence", 64'(fetch_cyc[i+1] - fetch_cyc[i]), 64'd2);

        // Backpressure: instruction at 0x10 must hold for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_valid", {63'h0, bus.ir_valid}, 64'h1);
            chk("bp_pc", bus.ir_pc, 64'h10);
            chk("bp_data", {32'h0, bus.ir_data}, {32'h0, mem_word(64'h10)});
        end
        consume(PS_REG, 64'h1000, '0, 64'h10, 64'h1000, 1);
        wait_ir_valid(64'h1000);

        // Relative branches around 0x40.
        consume(PS_REG, 64'h40, '0, 64'h1000, 64'h40, 1);
        wait_ir_valid(64'h40);
        consume(PS_REL, '0, 26'h3FF_FFFE, 64'h40, 64'h38, 1);
        wait_ir_valid(64'h38);
        consume(PS_REG, 64'h40, '0, 64'h38, 64'h40, 1);
        wait_ir_valid(64'h40);
        consume(PS_REL, '0, 26'h1, 64'h40, 64'h44, 1);
        wait_ir_valid(64'h44);

        // Halt at 0x20, then resume and re-fetch it.
        consume(PS_REG, 64'h20, '0, 64'h44, 64'h20, 1);
        wait_ir_valid(64'h20);
        consume(PS_HOLD, '0, '0, 64'h20, 64'h20, 0);
        for (int i = 0; i < 3; i++) begin
            chk("halt_halted", {63'h0, halted}, 64'h1);
            chk("halt_req", {63'h0, bus.imem_req}, 64'h0);
            @(negedge clock);
        end
        chk("halt_retire", {32'h0, retire_count}, 64'(exp_retire));
        exp_fetch_q.push_back(64'h20);
        resume = 1'b1;
        @(negedge clock);
        resume = 1'b0;
        chk("resume_halted", {63'h0, halted}, 64'h0);
        chk("resume_addr", bus.imem_addr, 64'h20);
        wait_ir_valid(64'h20);

        // Flush one cycle after a 3-wait request to 0x24 is issued.
        latency = 3;
        consume(PS_INC, '0, '0, 64'h20, 64'h24, 1);
        exp_fetch_q.push_back(64'h200);
        @(negedge clock);
        flush = 1'b1;
        flush_pc = 64'h200;
        @(negedge clock);
        flush = 1'b0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            chk("fw_req", {63'h0, bus.imem_req}, 64'h1);
            chk("fw_addr", bus.imem_addr, 64'h24);
            if (bus.imem_valid) begin
                got = 1;
                break;
            end
            @(negedge clock);
        end
        chk("fw_timeout", {63'h0, got}, 64'h1);
        wait_ir_valid(64'h200);
        chk("fw_retire", {32'h0, retire_count}, 64'(exp_retire));

        // Flush together with a consume: consume and ps are ignored.
        latency = 0;
        exp_fetch_q.push_back(64'h300);
        ps = PS_REG;
        reg_target = 64'h999;
        bus.ir_ready = 1'b1;
        flush = 1'b1;
        flush_pc = 64'h300;
        @(negedge clock);
        flush = 1'b0;
        bus.ir_ready = 1'b0;
        chk("fc_retire", {32'h0, retire_count}, 64'(exp_retire));
        chk("fc_addr", bus.imem_addr, 64'h300);
        wait_ir_valid(64'h300);

        // Asynchronous reset between edges while FULL.
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ir_valid", {63'h0, bus.ir_valid}, 64'h0);
        chk("arst_retire", {32'h0, retire_count}, 64'h0);
        chk("arst_addr", bus.imem_addr, 64'h0);
        chk("arst_req", {63'h0, bus.imem_req}, 64'h1);
        repeat (2) @(negedge clock);

        chk("fetch_q_empty", 64'(exp_fetch_q.size()), 64'h0);
        chk("ir_q_empty", 64'(exp_ir_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage that replaces the fixed 64-bit PC/ROM/adder/4-way-mux path with a clocked, handshaked front end.
- Holds the PC and issues requests to a variable-latency instruction memory.
- Buffers one fetched instruction for decode.
- Computes the next PC from a 2-bit PC-select code. It also supports halt/resume, an external flush/redirect and a retired-instruction counter.

Parameters:
- ADDR_W, 64: PC and target width.
- INSTR_W, 32: instruction width.
- IMM_W, 26: branch immediate width, sign-extended.
- SHIFT, 2: left shift applied to the immediate. IMM_W+SHIFT <= ADDR_W is required (elaboration check).
- INC, 4: sequential PC increment.
- RESET_PC, 0: PC value after reset.
- CNT_W, 32: retire counter width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_req  out  1  fetch request; held with a stable address until imem_valid.
- imem_addr  out  ADDR_W  fetch address.
- imem_data  in  INSTR_W  fetched instruction; valid when imem_valid=1.
- imem_valid  in  1  response strobe; may be high in the same cycle as imem_req (combinational ROM).
- ir_valid  out  1  buffered instruction is available.
- ir_ready  in  1  decode accepts the instruction.
- ir_data  out  INSTR_W  buffered instruction.
- ir_pc  out  ADDR_W  address of ir_data.
- ps  in  2  PC select, sampled on consume: 00 hold/halt, 01 ir_pc+INC, 10 reg_target, 11 ir_pc+(sext(branch_imm)<<SHIFT).
- reg_target  in  ADDR_W  absolute target (register B path).
- branch_imm  in  IMM_W  relative offset.
- flush  in  1  redirect pulse.
- flush_pc  in  ADDR_W  redirect target.
- resume  in  1  leave HALT.
- halted  out  1  high in HALT.
- retire_count  out  CNT_W  number of consumed instructions.

Behaviour:
- Reset (asynchronous, active-high). Values forced:
  - pc=RESET_PC, state=FETCH
  - ir_valid=0, ir_data=0, ir_pc=0
  - retire_count=0, halted=0
- Because state=FETCH, imem_req=1 in the first cycle after reset release.
- Outputs in FETCH and FLUSH_WAIT:
  - imem_req=1 (combinational from state).
  - imem_addr=pc in FETCH; imem_addr=stale address register in FLUSH_WAIT.
- States: FETCH, FULL, HALT, FLUSH_WAIT.
- FETCH:
  - On imem_valid: ir_data<=imem_data, ir_pc<=pc, ir_valid<=1, go to FULL.
  - Timing: imem_valid in cycle N gives ir_valid=1 in cycle N+1.
- FULL:
  - Consume = ir_valid & ir_ready. On consume: retire_count+1 (wraps), ir_valid<=0.
  - Next PC by ps:
    - 01: pc<=ir_pc+INC, go to FETCH.
    - 10: pc<=reg_target, go to FETCH.
    - 11: pc<=ir_pc+(sext(branch_imm)<<SHIFT), go to FETCH.
    - 00: pc<=ir_pc, go to HALT.
  - Timing: the new imem_addr is visible in cycle N+1 after consume at N. Throughput with a 0-wait memory is 1 instruction per 2 cycles.
  - Without ir_ready: ir_data and ir_pc are held stable.
- HALT:
  - halted=1, imem_req=0.
  - resume: go to FETCH with pc unchanged, so the held instruction is re-fetched.
- Flush (priority: reset > flush > all else):
  - In FULL or HALT: ir_valid<=0, pc<=flush_pc, halted<=0, go to FETCH.
  - In FETCH with imem_valid=1 in the same cycle: response discarded, pc<=flush_pc, stay in FETCH.
  - In FETCH with imem_valid=0: latch the old address, pc<=flush_pc, go to FLUSH_WAIT.
  - A consume in the same cycle as flush is not counted.
  - A ps value in the same cycle as flush is ignored.
- FLUSH_WAIT:
  - Keeps imem_req=1 with the old address.
  - On imem_valid: data discarded, go to FETCH with the new pc.
  - Another flush in this state only updates pc.
- Arithmetic:
  - All PC arithmetic is modulo 2^ADDR_W.
  - Sign extension is from bit IMM_W-1.
- resume outside HALT is ignored.

Decomposition:
- Shared package fetch_pkg:
  - PS encodings PS_HOLD=2'b00, PS_INC=2'b01, PS_REG=2'b10, PS_REL=2'b11.
  - State encoding constants.
- Combinational sub-module fetch_next_pc (ps, ir_pc, reg_target, branch_imm → next_pc): sign-extend, shift, two adders and a 4:1 select.
- The FSM, buffer and counter stay in fetch_unit.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, RESET_PC=0, 0-wait memory, ps=01, ir_ready=1.
  - Required: imem_addr sequence 0,4,8,12 on every other cycle; retire_count=4 after four consumes.
- Relative branch:
  - Stimulus: ir_pc=0x40, ps=11, branch_imm=26'h3FFFFFE (-2).
  - Required: next imem_addr=0x38.
  - Also: branch_imm=1 gives 0x44.
- Register jump and backpressure:
  - Stimulus: ir_ready=0 for 5 cycles, then ps=10, reg_target=0x1000.
  - Required: ir_data and ir_pc stable throughout; then imem_addr=0x1000.
- Halt/resume:
  - Stimulus: ps=00 at ir_pc=0x20.
  - Required: halted=1, imem_req=0; after resume, imem_addr=0x20.
- Flush with an outstanding request:
  - Stimulus: 3-cycle memory latency; flush with flush_pc=0x200 one cycle after the request.
  - Required: imem_addr held at the old value until imem_valid; that data is never seen on ir_data; next request is to 0x200.
- Asynchronous reset mid-FULL:
  - Stimulus: assert reset between clock edges while in FULL.
  - Required: ir_valid=0, retire_count=0, pc=RESET_PC immediately, not waiting for a clock edge.
